// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, constants and helpers for the 1R1W clearable RAM
//
// Purpose: FSM state type, read-during-write policy constants, byte-count
// helper and the byte-merge function used by the write path and RDW bypass.
// Ports: none (package).

package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word byte_merge can handle; callers size-cast in and out of it.
  localparam int MERGE_MAX_W = 256;

  function automatic int calc_nb(input int d_width, input int byte_width);
    return d_width / byte_width;
  endfunction

  // Replace every byte of old_w whose enable bit is set with the matching
  // byte of new_w. Enables beyond the caller's byte count arrive as zero.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] be,
    input int                     byte_width
  );
    logic [MERGE_MAX_W-1:0] res;
    logic [7:0]             idx;
    res = old_w;
    for (int b = 0; b < MERGE_MAX_W; b++) begin
      idx = 8'(b / byte_width);
      if (be[idx]) res[b] = new_w[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_core_1r1w.sv
// rtl/ram_core_1r1w.sv - bare storage array, byte-enable write, registered read
//
// Purpose: 2**AW x DW storage with no reset. A read returns the word as it was
// before any write at the same edge (old-data behaviour).
// Ports:
//   clk      clock
//   we/wa/wd write enable, address, data
//   wbe      per-byte write enables (bit i covers wd[i*BW +: BW])
//   re/ra    read enable, address
//   rd       registered read data, holds while re=0

module ram_core_1r1w
  import ram_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 5,
  parameter int BW = 8,
  parameter int NB = calc_nb(DW, BW)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [NB-1:0] wbe,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem_q[wa][i*BW +: BW] <= wd[i*BW +: BW];
      end
    end
    if (re) rd_q <= mem_q[ra];
  end

  assign rd = rd_q;

endmodule

// File: rtl/ram_1r1w_clr.sv
// rtl/ram_1r1w_clr.sv - 1R1W RAM with byte enables, RDW policy, output reg and clear engine
//
// Purpose: wraps ram_core_1r1w with an IDLE/CLEAR FSM that zeroes the array
// after reset (optional) or on clear_req, a same-address read-during-write
// bypass, and an optional extra output register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ready                high in IDLE; we/re/clear_req only accepted then
//   clear_req            starts a full-array clear
//   we, wa, wd, wbe      write port with byte enables
//   re, ra               read port request
//   rd, rd_valid         read data and one-cycle completion flag

module ram_1r1w_clr
  import ram_pkg::*;
#(
  parameter int D_WIDTH        = 16,
  parameter int A_WIDTH        = 5,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  output logic                                       ready,
  input  logic                                       clear_req,
  input  logic                                       we,
  input  logic [A_WIDTH-1:0]                         wa,
  input  logic [D_WIDTH-1:0]                         wd,
  input  logic [calc_nb(D_WIDTH, BYTE_WIDTH)-1:0]    wbe,
  input  logic                                       re,
  input  logic [A_WIDTH-1:0]                         ra,
  output logic [D_WIDTH-1:0]                         rd,
  output logic                                       rd_valid
);

  localparam int     NB          = calc_nb(D_WIDTH, BYTE_WIDTH);
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   cnt_q, cnt_d;
  logic                 clearing;
  logic                 accept_wr, accept_rd;

  assign clearing  = (state_q == ST_CLEAR);
  assign ready     = (state_q == ST_IDLE);
  assign accept_wr = ready & we;
  assign accept_rd = ready & re;

  // Clear engine: one zero word per cycle, leave CLEAR after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (clear_req) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (cnt_q == '1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + A_WIDTH'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write mux: the clear engine owns the write port while clearing.
  logic                 mem_we;
  logic [A_WIDTH-1:0]   mem_wa;
  logic [D_WIDTH-1:0]   mem_wd;
  logic [NB-1:0]        mem_wbe;
  logic [D_WIDTH-1:0]   core_rd;

  assign mem_we  = clearing | accept_wr;
  assign mem_wa  = clearing ? cnt_q : wa;
  assign mem_wd  = clearing ? '0    : wd;
  assign mem_wbe = clearing ? '1    : wbe;

  ram_core_1r1w #(
    .DW(D_WIDTH),
    .AW(A_WIDTH),
    .BW(BYTE_WIDTH),
    .NB(NB)
  ) u_core (
    .clk (clk),
    .we  (mem_we),
    .wa  (mem_wa),
    .wd  (mem_wd),
    .wbe (mem_wbe),
    .re  (accept_rd),
    .ra  (ra),
    .rd  (core_rd)
  );

  // The core always returns old data; for new-data mode remember the colliding
  // write and merge it over the core output. has_data_q keeps rd at zero until
  // the first read after reset, since the core array/register are unreset.
  logic                 byp_hit_q;
  logic [D_WIDTH-1:0]   byp_wd_q;
  logic [NB-1:0]        byp_be_q;
  logic                 has_data_q;
  logic                 v1_q;
  logic [D_WIDTH-1:0]   merged;
  logic [D_WIDTH-1:0]   stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_wd_q   <= '0;
      byp_be_q   <= '0;
      has_data_q <= 1'b0;
      v1_q       <= 1'b0;
    end else begin
      v1_q <= accept_rd;
      if (accept_rd) begin
        has_data_q <= 1'b1;
        byp_hit_q  <= (RDW_MODE == RDW_NEW) && accept_wr && (wa == ra);
        byp_wd_q   <= wd;
        byp_be_q   <= wbe;
      end
    end
  end

  assign merged = D_WIDTH'(byte_merge(MERGE_MAX_W'(core_rd), MERGE_MAX_W'(byp_wd_q),
                                      MERGE_MAX_W'(byp_be_q), BYTE_WIDTH));
  assign stage1 = !has_data_q ? '0 : (byp_hit_q ? merged : core_rd);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [D_WIDTH-1:0] rd2_q;
      logic               v2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_q <= '0;
          v2_q  <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) rd2_q <= stage1;
        end
      end
      assign rd       = rd2_q;
      assign rd_valid = v2_q;
    end else begin : g_no_out_reg
      assign rd       = stage1;
      assign rd_valid = v1_q;
    end
  endgenerate

endmodule
